parallel_to_serial: RTL and testbench

Free-running parallel-in, serial-out converter. It captures a WIDTH-bit word from parallel_i and shifts it out on serial_o, LSB first, one bit per clock. When the last bit of a word is being presented, it reloads the next word with no idle gap. valid_o flags serial bits in flight; empty_o flags that no word has been loaded yet.

---
 rtl/parallel_to_serial.sv | 75 +++++++
 tb/tb_parallel_to_serial.sv | 136 +++++++++++++
 2 files changed

// File: rtl/parallel_to_serial.sv
// Parallel-in, serial-out converter.
// Captures a WIDTH-bit word and shifts it out LSB first, one bit per clock.
// The next word is captured on the edge that ends the last bit, so a loaded
// converter streams continuously with no idle cycles.
//
// Output semantics: valid_o = 1 means serial_o carries a data bit this cycle.
// There is no back-pressure: the stream is free-running and a consumer must
// accept every bit while valid_o is high. empty_o is always the complement of
// valid_o.
module parallel_to_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_i,
    output logic             empty_o,
    output logic             serial_o,
    output logic             valid_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    // ST_EMPTY: nothing captured yet; ST_SHIFT: a word is being presented.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             load;

    // Load when idle or while the final bit of the current word is presented.
    assign load = (state_q == ST_EMPTY) || (cnt_q == LAST_IDX);

    // Next-state, shift-register and bit-counter update.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = ST_SHIFT;
            sr_d    = parallel_i;
            cnt_d   = '0;
        end else begin
            sr_d    = {1'b0, sr_q[WIDTH-1:1]};
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // State registers; reset clears everything immediately and aborts any word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs come straight from registers; parallel_i never reaches them
    // combinationally.
    assign serial_o = sr_q[0];
    assign valid_o  = (state_q == ST_SHIFT);
    assign empty_o  = (state_q == ST_EMPTY);

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial (WIDTH = 4).
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_parallel_to_serial;

    logic       clk;
    logic       reset;
    logic [3:0] parallel_i;
    logic       empty_o;
    logic       serial_o;
    logic       valid_o;

    int checks   = 0;
    int failures = 0;

    logic [3:0] word_q [$];
    logic [3:0] w;

    parallel_to_serial #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .parallel_i (parallel_i),
        .empty_o    (empty_o),
        .serial_o   (serial_o),
        .valid_o    (valid_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard compare
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait one cycle and check one presented data bit
    task automatic bit_chk(input string tag, input int k, input logic exp_bit);
        @(negedge clk);
        chk($sformatf("%s_bit%0d_serial", tag, k), {3'b0, serial_o}, {3'b0, exp_bit});
        chk($sformatf("%s_bit%0d_valid", tag, k), {3'b0, valid_o}, 4'd1);
        chk($sformatf("%s_bit%0d_empty", tag, k), {3'b0, empty_o}, 4'd0);
    endtask

    // Check the reset-state outputs
    task automatic idle_chk(input string tag);
        chk({tag, "_serial"}, {3'b0, serial_o}, 4'd0);
        chk({tag, "_valid"},  {3'b0, valid_o},  4'd0);
        chk({tag, "_empty"},  {3'b0, empty_o},  4'd1);
    endtask

    // Invariant: valid and empty never both high
    always @(posedge clk) begin
        checks++;
        assert (!(valid_o && empty_o)) else begin
            failures++;
            $error("FAIL invariant: valid_o=%0b empty_o=%0b required not both 1", valid_o, empty_o);
        end
    end

    // Directed stimulus
    initial begin
        reset      = 1'b0;
        parallel_i = 4'hF;

        // Reset held for two cycles
        @(negedge clk); idle_chk("rst_c0");
        @(negedge clk); idle_chk("rst_c1");

        // First load: 1010 -> 0,1,0,1
        reset      = 1'b1;
        parallel_i = 4'b1010;
        bit_chk("w1010", 0, 1'b0);
        bit_chk("w1010", 1, 1'b1);
        bit_chk("w1010", 2, 1'b0);
        bit_chk("w1010", 3, 1'b1);
        parallel_i = 4'b1111;

        // Back-to-back: 1111 with no bubble
        bit_chk("w1111", 0, 1'b1);
        bit_chk("w1111", 1, 1'b1);
        bit_chk("w1111", 2, 1'b1);
        bit_chk("w1111", 3, 1'b1);
        parallel_i = 4'b0110;

        // Input stability: 0110 with parallel_i toggled mid-word
        bit_chk("w0110", 0, 1'b0);
        bit_chk("w0110", 1, 1'b1);
        parallel_i = 4'b1001;
        bit_chk("w0110", 2, 1'b1);
        bit_chk("w0110", 3, 1'b0);

        // 1001 still present at the load edge, so it is taken: 1,0,0,1
        bit_chk("w1001", 0, 1'b1);
        bit_chk("w1001", 1, 1'b0);
        bit_chk("w1001", 2, 1'b0);
        bit_chk("w1001", 3, 1'b1);
        parallel_i = 4'b1100;

        // Mid-word reset after two bits of 1100
        bit_chk("w1100", 0, 1'b0);
        bit_chk("w1100", 1, 1'b0);
        reset      = 1'b0;
        parallel_i = 4'b0011;
        #1;
        idle_chk("async_rst");
        @(negedge clk);
        idle_chk("rst_hold");

        // Release: fresh word 0011 -> 1,1,0,0
        reset = 1'b1;
        bit_chk("w0011", 0, 1'b1);
        bit_chk("w0011", 1, 1'b1);
        bit_chk("w0011", 2, 1'b0);
        bit_chk("w0011", 3, 1'b0);

        // Five random words, each held for four cycles
        for (int i = 0; i < 5; i++) word_q.push_back(4'($urandom_range(0, 15)));
        parallel_i = word_q[0];
        for (int i = 0; i < 5; i++) begin
            w = word_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                bit_chk($sformatf("rnd%0d_%0h", i, w), k, w[k]);
            end
            if (word_q.size() > 0) parallel_i = word_q[0];
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
